// File: rtl/rangos_temp_ctrl.sv
// Saturating set-point controller: edge-stepped up/down, clamped load, registered outputs.
// Define RANGOS_AUTOREPEAT_EN to add hold-to-auto-repeat (DELAY then periodic REPEAT steps).
module rangos_temp_ctrl #(
   parameter int WIDTH      = 4,
   parameter int MIN_VAL    = 0,
   parameter int MAX_VAL    = 15,
   parameter int RESET_VAL  = 0,
   parameter int REP_DELAY  = 8,
   parameter int REP_PERIOD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cup,
   input  logic             cdown,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] temp,
   output logic             at_min,
   output logic             at_max,
   output logic             changed
);
   localparam logic [WIDTH:0]   MIN_X   = (WIDTH+1)'(MIN_VAL);
   localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

   logic [1:0]       sync_q;
   logic             run;
   logic [WIDTH-1:0] temp_q, temp_d;
   logic             changed_q, changed_d;
   logic             cup_q, cup_d, cdown_q, cdown_d;
   logic             up_edge, dn_edge, step_up, step_dn;
   logic [WIDTH:0]   temp_x, load_x, sum_x;

`ifdef RANGOS_AUTOREPEAT_EN
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
   localparam int CNT_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int CW      = $clog2(CNT_MAX);
   state_t          state_q, state_d;
   logic            dir_up_q, dir_up_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            held;
`else
   logic unused_rep_cfg;
   assign unused_rep_cfg = (REP_DELAY > 0) ^ (REP_PERIOD > 0);
`endif

   // Reset deassertion is synchronised; the core only samples once run is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= 2'b00;
      else      sync_q <= {sync_q[0], 1'b1};
   end
   assign run = sync_q[1];

   always_comb begin
      temp_x    = {1'b0, temp_q};
      load_x    = {1'b0, load_val};
      sum_x     = temp_x + 1'b1;
      up_edge   = cup & ~cup_q;
      dn_edge   = cdown & ~cdown_q;
      step_up   = 1'b0;
      step_dn   = 1'b0;
      temp_d    = temp_q;
      cup_d     = cup;
      cdown_d   = cdown;
`ifdef RANGOS_AUTOREPEAT_EN
      state_d   = state_q;
      dir_up_d  = dir_up_q;
      cnt_d     = cnt_q;
      held      = dir_up_q ? cup : cdown;
`endif
      // Until run, pretend both buttons were already high so a held button is not an edge.
      if (!run) begin
         cup_d   = 1'b1;
         cdown_d = 1'b1;
      end else if (load) begin
         if (load_x < MIN_X)      temp_d = MIN_V;
         else if (load_x > MAX_X) temp_d = MAX_V;
         else                     temp_d = load_val;
`ifdef RANGOS_AUTOREPEAT_EN
         state_d = IDLE;
`endif
      end else if (cup & cdown) begin
`ifdef RANGOS_AUTOREPEAT_EN
         state_d = IDLE;
`endif
      end else if (up_edge) begin
         step_up = 1'b1;
`ifdef RANGOS_AUTOREPEAT_EN
         state_d  = DELAY;
         dir_up_d = 1'b1;
         cnt_d    = '0;
`endif
      end else if (dn_edge) begin
         step_dn = 1'b1;
`ifdef RANGOS_AUTOREPEAT_EN
         state_d  = DELAY;
         dir_up_d = 1'b0;
         cnt_d    = '0;
`endif
      end
`ifdef RANGOS_AUTOREPEAT_EN
      else if (state_q != IDLE) begin
         if (!held) begin
            state_d = IDLE;
         end else if (state_q == DELAY) begin
            if (cnt_q == CW'(REP_DELAY-1)) begin
               step_up = dir_up_q;
               step_dn = ~dir_up_q;
               state_d = REPEAT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if (cnt_q == CW'(REP_PERIOD-1)) begin
               step_up = dir_up_q;
               step_dn = ~dir_up_q;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
`endif
      if (step_up && (sum_x <= MAX_X)) temp_d = sum_x[WIDTH-1:0];
      if (step_dn && (temp_x > MIN_X)) temp_d = temp_q - 1'b1;
      changed_d = (temp_d != temp_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         temp_q    <= RESET_V;
         changed_q <= 1'b0;
         cup_q     <= 1'b0;
         cdown_q   <= 1'b0;
`ifdef RANGOS_AUTOREPEAT_EN
         state_q   <= IDLE;
         dir_up_q  <= 1'b0;
         cnt_q     <= '0;
`endif
      end else begin
         temp_q    <= temp_d;
         changed_q <= changed_d;
         cup_q     <= cup_d;
         cdown_q   <= cdown_d;
`ifdef RANGOS_AUTOREPEAT_EN
         state_q   <= state_d;
         dir_up_q  <= dir_up_d;
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign temp    = temp_q;
   assign changed = changed_q;
   assign at_min  = (temp_q == MIN_V);
   assign at_max  = (temp_q == MAX_V);
endmodule

// File: tb/tb_rangos_temp_ctrl.sv
// Bench for rangos_temp_ctrl: two instances (default range and 2..12) fed the same
// directed stimulus, checked every cycle against a rule-level model plus literal pins.
module tb_rangos_temp_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cup = 1'b0;
   logic       cdown = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] temp_a, temp_b;
   logic       at_min_a, at_max_a, changed_a;
   logic       at_min_b, at_max_b, changed_b;

   int checks = 0;
   int failures = 0;
   int chg_a = 0;
   bit cmp_en = 1'b0;

`ifdef RANGOS_AUTOREPEAT_EN
   localparam int REP_D = 8;
   localparam int REP_P = 4;
   localparam int HOLD_A = 5, HOLD_B = 7, HOLD_PULSES = 5;
`else
   localparam int HOLD_A = 1, HOLD_B = 3, HOLD_PULSES = 1;
`endif

   always #5 clk = ~clk;

   rangos_temp_ctrl u_a (
      .clk(clk), .rst(rst), .cup(cup), .cdown(cdown), .load(load), .load_val(load_val),
      .temp(temp_a), .at_min(at_min_a), .at_max(at_max_a), .changed(changed_a)
   );

   rangos_temp_ctrl #(
      .WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .RESET_VAL(2), .REP_DELAY(8), .REP_PERIOD(4)
   ) u_b (
      .clk(clk), .rst(rst), .cup(cup), .cdown(cdown), .load(load), .load_val(load_val),
      .temp(temp_b), .at_min(at_min_b), .at_max(at_max_b), .changed(changed_b)
   );

   // ---------------- model ----------------
   int m_lo [2] = '{0, 2};
   int m_hi [2] = '{15, 12};
   int m_rv [2] = '{0, 2};
   int m_temp [2];
   bit m_chg [2];
   bit m_rep [2];
   bit m_dir [2];
   int m_len [2];
   bit m_pu, m_pd;

   function automatic int limit(input int v, input int d);
      if (v < m_lo[d]) return m_lo[d];
      if (v > m_hi[d]) return m_hi[d];
      return v;
   endfunction

   task automatic model_edge(input int d);
      int nt;
      nt = m_temp[d];
      if (load) begin
         nt = limit(int'(load_val), d);
         m_rep[d] = 1'b0;
      end else if (cup && cdown) begin
         m_rep[d] = 1'b0;
      end else if (cup && !m_pu) begin
         nt = limit(nt + 1, d);
         m_rep[d] = 1'b1; m_dir[d] = 1'b1; m_len[d] = 0;
      end else if (cdown && !m_pd) begin
         nt = limit(nt - 1, d);
         m_rep[d] = 1'b1; m_dir[d] = 1'b0; m_len[d] = 0;
      end else if (m_rep[d]) begin
         if (!(m_dir[d] ? cup : cdown)) begin
            m_rep[d] = 1'b0;
         end else begin
            m_len[d] = m_len[d] + 1;
`ifdef RANGOS_AUTOREPEAT_EN
            if (m_len[d] >= REP_D && ((m_len[d] - REP_D) % REP_P) == 0)
               nt = limit(nt + (m_dir[d] ? 1 : -1), d);
`endif
         end
      end
      m_chg[d]  = (nt != m_temp[d]);
      m_temp[d] = nt;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            m_temp[d] = m_rv[d];
            m_chg[d]  = 1'b0;
            m_rep[d]  = 1'b0;
            m_dir[d]  = 1'b0;
            m_len[d]  = 0;
         end
         m_pu = 1'b1;
         m_pd = 1'b1;
      end else begin
         for (int d = 0; d < 2; d++) model_edge(d);
         m_pu = cup;
         m_pd = cdown;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst && cmp_en) begin
         check("model_temp_a",    temp_a,    m_temp[0]);
         check("model_at_min_a",  at_min_a,  m_temp[0] == m_lo[0]);
         check("model_at_max_a",  at_max_a,  m_temp[0] == m_hi[0]);
         check("model_changed_a", changed_a, m_chg[0]);
         check("model_temp_b",    temp_b,    m_temp[1]);
         check("model_at_min_b",  at_min_b,  m_temp[1] == m_lo[1]);
         check("model_at_max_b",  at_max_b,  m_temp[1] == m_hi[1]);
         check("model_changed_b", changed_b, m_chg[1]);
      end
   end

   always @(negedge clk) begin
      if (rst && changed_a) chg_a++;
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_up();
      cup = 1'b1; tick();
      cup = 1'b0; tick();
   endtask

   task automatic pulse_down();
      cdown = 1'b1; tick();
      cdown = 1'b0; tick();
   endtask

   task automatic do_load(input logic [3:0] v);
      load = 1'b1; load_val = v; tick();
      load = 1'b0; tick();
   endtask

   initial begin
      int c0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_temp_a",    temp_a,    0);
      check("reset_at_min_a",  at_min_a,  1);
      check("reset_at_max_a",  at_max_a,  0);
      check("reset_changed_a", changed_a, 0);
      check("reset_temp_b",    temp_b,    2);
      check("reset_at_min_b",  at_min_b,  1);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (4) tick();
      cmp_en = 1'b1;

      c0 = chg_a;
      repeat (3) pulse_up();
      @(negedge clk);
      check("three_up_temp_a",  temp_a, 3);
      check("three_up_pulses",  chg_a - c0, 3);
      check("three_up_temp_b",  temp_b, 5);

      do_load(4'd15);
      @(negedge clk);
      check("load15_temp_a", temp_a, 15);
      check("load15_clamp_b", temp_b, 12);
      c0 = chg_a;
      pulse_up();
      @(negedge clk);
      check("sat_max_temp_a",   temp_a, 15);
      check("sat_max_at_max_a", at_max_a, 1);
      check("sat_max_pulses",   chg_a - c0, 0);
      check("sat_max_temp_b",   temp_b, 12);

      do_load(4'd0);
      @(negedge clk);
      check("load0_clamp_b", temp_b, 2);
      c0 = chg_a;
      pulse_down();
      @(negedge clk);
      check("sat_min_temp_a", temp_a, 0);
      check("sat_min_pulses", chg_a - c0, 0);

      load = 1'b1; load_val = 4'd7; cup = 1'b1;
      tick();
      @(negedge clk);
      check("load_wins_a", temp_a, 7);
      check("load_wins_b", temp_b, 7);
      load = 1'b0;
      tick();
      cup = 1'b0;
      tick();

      do_load(4'd5);
      cup = 1'b1; cdown = 1'b1;
      tick();
      @(negedge clk);
      check("both_temp_a",    temp_a, 5);
      check("both_changed_a", changed_a, 0);
      cup = 1'b0; cdown = 1'b0;
      tick();

      do_load(4'd0);
      c0 = chg_a;
      cup = 1'b1;
      repeat (21) tick();
      cup = 1'b0;
      repeat (6) tick();
      @(negedge clk);
      check("hold_temp_a", temp_a, HOLD_A);
      check("hold_temp_b", temp_b, HOLD_B);
      check("hold_pulses", chg_a - c0, HOLD_PULSES);

      do_load(4'd9);
      cup = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      #2;
      check("midrst_temp_a",    temp_a, 0);
      check("midrst_temp_b",    temp_b, 2);
      check("midrst_changed_a", changed_a, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (14) tick();
      @(negedge clk);
      check("held_after_rst_a", temp_a, 0);
      check("held_after_rst_b", temp_b, 2);
      cup = 1'b0;
      tick();
      pulse_up();
      @(negedge clk);
      check("repress_temp_a", temp_a, 1);
      check("repress_temp_b", temp_b, 3);

      do_load(4'd3);
      pulse_down();
      pulse_down();
      @(negedge clk);
      check("down_temp_a",   temp_a, 1);
      check("down_temp_b",   temp_b, 2);
      check("down_at_min_b", at_min_b, 1);

      repeat (3) tick();
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
